// File: rtl/tuser_out_fsm.sv
// Output stage of the SDNet wrapper: queues one tuple per packet and re-attaches it as tuser
// to the outgoing AXIS packet. Beats pass through with zero latency.
module tuser_out_fsm #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic                tout_aclk,
  input  logic                tout_arst,
  input  logic                tout_tvalid,
  input  logic [127:0]        tout_tdata,
  input  logic                tout_avalid,
  input  logic [255:0]        tout_adata,
  input  logic [31:0]         tout_akeep,
  input  logic                tout_alast,
  output logic                tout_aready,
  output logic                tout_mvalid,
  output logic [255:0]        tout_mdata,
  output logic [31:0]         tout_mkeep,
  output logic                tout_mlast,
  output logic [127:0]        tout_muser,
  input  logic                tout_mready,
  output logic [ADDR_W:0]     tout_level,
  output logic                tout_ovf
);

  localparam int unsigned LVL_W = ADDR_W + 1;

  typedef enum logic {
    S_SOP  = 1'b0,
    S_BODY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [127:0]        mem_q [DEPTH];

  logic                not_empty;
  logic                accept;
  logic                push;
  logic                pop;
  logic [127:0]        head;

  assign not_empty = (level_q != '0);
  assign head      = mem_q[rd_ptr_q];

  // Data path is a straight wire; only valid/ready/user are controlled.
  assign tout_mdata = tout_adata;
  assign tout_mkeep = tout_akeep;
  assign tout_mlast = tout_alast;
  assign tout_level = level_q;
  assign tout_ovf   = ovf_q;

  always_ff @(posedge tout_aclk) begin
    if (tout_arst) begin
      state_q  <= S_SOP;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge tout_aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tout_tdata;
    end
  end

  // Handshake and packet tracking; a packet stalls at its first beat until a tuple is queued.
  always_comb begin
    state_d     = state_q;
    tout_aready = 1'b0;
    tout_mvalid = 1'b0;
    tout_muser  = '0;
    pop         = 1'b0;
    accept      = 1'b0;
    if (!tout_arst) begin
      unique case (state_q)
        S_SOP: begin
          tout_mvalid = tout_avalid & not_empty;
          tout_aready = tout_mready & not_empty;
          tout_muser  = not_empty ? head : '0;
          accept      = tout_avalid & tout_aready;
          if (accept) begin
            if (tout_alast) begin
              pop = 1'b1;
            end else begin
              state_d = S_BODY;
            end
          end
        end
        S_BODY: begin
          tout_mvalid = tout_avalid;
          tout_aready = tout_mready;
          tout_muser  = head;
          accept      = tout_avalid & tout_aready;
          if (accept && tout_alast) begin
            pop     = not_empty;
            state_d = S_SOP;
          end
        end
        default: state_d = S_SOP;
      endcase
    end
  end

  // Tuple FIFO bookkeeping; a pop in the same cycle frees room for a push at full.
  always_comb begin
    push     = tout_tvalid & ((level_q < LVL_W'(DEPTH)) | pop);
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    ovf_d    = ovf_q | (tout_tvalid & ~push);
  end

endmodule
